// File: rtl/fifo_status_pkg.sv
// Shared types and helpers for the multi-channel FIFO status controller.
// Channel state encoding, direction/mode constants and packed-slice access.
package fifo_status_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_RST,
    ST_IDLE,
    ST_PEND,
    ST_ACTIVE,
    ST_FSH,
    ST_HOLD
  } ch_state_e;

  localparam logic [39:0] WR_READ   = "READ";
  localparam logic [39:0] WR_WRITE  = "WRITE";
  localparam logic [39:0] MODE_ONCE = "ONCE";
  localparam logic [39:0] MODE_LINE = "LINE";

  localparam int SLICE_VW = 256;

  // Field idx of width w (w <= 31) from a packed per-channel vector.
  function automatic logic [31:0] slice_at(
    input logic [SLICE_VW-1:0] vec,
    input int idx,
    input int w
  );
    logic [SLICE_VW-1:0] sh;
    sh = vec >> (idx * w);
    return sh[31:0] & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/fifo_status_ch.sv
// One FIFO channel: registered trigger, fsync blanking, reset-wait counter
// and the request state machine seen by the shared arbiter.
module fifo_status_ch
  import fifo_status_pkg::*;
#(
  parameter int CNT_W = 10,
  parameter int LSIZE = 9,
  parameter int FULL_LEN = 256,
  parameter int THRESHOLD = 200,
  parameter int BURST_LEN = 100,
  parameter logic [39:0] MODE = "ONCE",
  parameter logic [39:0] WR_RD = "READ",
  parameter int RST_WAIT = 31,
  parameter int BLANK_CYC = 4
) (
  input  logic clock,
  input  logic rst,
  input  logic enable,
  input  logic [CNT_W-1:0] count,
  input  logic fsync,
  input  logic tail_status,
  input  logic [LSIZE-1:0] tail_len,
  input  logic frame_tail_leave,
  input  logic accept,
  input  logic done_evt,
  input  logic abort,
  output logic pend,
  output logic [LSIZE-1:0] len,
  output logic tail,
  output logic burst_done,
  output logic tail_done
);

  localparam int LOW = FULL_LEN - THRESHOLD;
  localparam int RW_W = $clog2(RST_WAIT + 2);
  localparam int BL_W = $clog2(BLANK_CYC + 2);
  localparam bit IS_WR = (WR_RD == WR_WRITE);
  localparam bit IS_LINE = (MODE == MODE_LINE);

  ch_state_e state, nxt;
  logic trig;
  logic cmp;
  logic zero_tail;
  logic fsync_seen;
  logic [BL_W-1:0] blank;
  logic [RW_W-1:0] rst_cnt;

  assign cmp = IS_WR ? (count > CNT_W'(THRESHOLD))
                     : (count < CNT_W'(LOW));
  assign zero_tail = tail_status && (tail_len == '0);

  always_ff @(posedge clock) begin
    if (rst) state <= ST_WAIT_RST;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_WAIT_RST:
        if (!fsync && rst_cnt == RW_W'(RST_WAIT)) nxt = ST_IDLE;
      ST_IDLE:
        if (trig) nxt = zero_tail ? ST_FSH : ST_PEND;
      ST_PEND:
        if (accept)     nxt = ST_ACTIVE;
        else if (fsync) nxt = ST_WAIT_RST;
      ST_ACTIVE:
        if (abort) nxt = ST_WAIT_RST;
        else if (done_evt)
          nxt = (fsync_seen || fsync) ? ST_WAIT_RST : ST_FSH;
      ST_FSH:
        if (!tail)                             nxt = ST_IDLE;
        else if (IS_LINE && !frame_tail_leave) nxt = ST_IDLE;
        else                                   nxt = ST_HOLD;
      ST_HOLD:
        if (fsync) nxt = ST_IDLE;
      default: nxt = ST_WAIT_RST;
    endcase
  end

  always_comb begin
    pend       = (state == ST_PEND);
    burst_done = (state == ST_FSH) && !tail;
    tail_done  = (state == ST_FSH) && tail;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      trig       <= 1'b0;
      blank      <= '0;
      rst_cnt    <= '0;
      len        <= LSIZE'(BURST_LEN);
      tail       <= 1'b0;
      fsync_seen <= 1'b0;
    end else begin
      trig <= enable && cmp && !fsync && (blank == '0);
      if (fsync)              blank <= BL_W'(BLANK_CYC);
      else if (blank != '0)   blank <= blank - BL_W'(1);
      if (state != ST_WAIT_RST || fsync) rst_cnt <= '0;
      else                               rst_cnt <= rst_cnt + RW_W'(1);
      if (state == ST_IDLE && trig) begin
        len  <= tail_status ? tail_len : LSIZE'(BURST_LEN);
        tail <= tail_status;
      end
      // fsync racing the acceptance is handled as fsync during ACTIVE
      if (state == ST_PEND)        fsync_seen <= accept && fsync;
      else if (state == ST_ACTIVE) fsync_seen <= fsync_seen || fsync;
      else                         fsync_seen <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_status_ctrl_mc.sv
// Multi-channel FIFO status controller with round-robin DMA request arbiter.
// Optional done watchdog enabled by defining FIFO_STATUS_TIMEOUT_EN.
module fifo_status_ctrl_mc
  import fifo_status_pkg::*;
#(
  parameter int CH_NUM = 2,
  parameter int CNT_W = 10,
  parameter int LSIZE = 9,
  parameter int FULL_LEN = 256,
  parameter int THRESHOLD = 200,
  parameter int BURST_LEN = 100,
  parameter logic [39:0] MODE = "ONCE",
  parameter logic [39:0] WR_RD = "READ",
  parameter int RST_WAIT = 31,
  parameter int BLANK_CYC = 4,
  parameter int TIMEOUT_CYC = 4096,
  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic clock,
  input  logic rst,
  input  logic [CH_NUM-1:0] enable,
  input  logic [CH_NUM*CNT_W-1:0] count,
  input  logic [CH_NUM-1:0] fsync,
  input  logic [CH_NUM-1:0] tail_status,
  input  logic [CH_NUM*LSIZE-1:0] tail_len,
  input  logic [CH_NUM-1:0] frame_tail_leave,
  output logic req_valid,
  output logic [CH_W-1:0] req_ch,
  output logic [LSIZE-1:0] req_len,
  output logic req_tail,
  input  logic resp,
  input  logic done,
  output logic [CH_NUM-1:0] burst_done,
  output logic [CH_NUM-1:0] tail_done,
  output logic [CH_NUM-1:0] err
);

  logic [CH_NUM-1:0] pend, tail_v, sel, elig;
  logic [CH_NUM-1:0] accept, done_evt, abort;
  logic [LSIZE-1:0] len_v [CH_NUM];
  logic outstanding, gnt_hit, tmo;
  logic [CH_W-1:0] rr, gnt;
  int idx;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    assign sel[i]      = (req_ch == CH_W'(i));
    assign accept[i]   = req_valid && resp && sel[i];
    assign done_evt[i] = done && outstanding && sel[i];
    assign abort[i]    = tmo && sel[i];

    fifo_status_ch #(
      .CNT_W(CNT_W), .LSIZE(LSIZE), .FULL_LEN(FULL_LEN),
      .THRESHOLD(THRESHOLD), .BURST_LEN(BURST_LEN),
      .MODE(MODE), .WR_RD(WR_RD),
      .RST_WAIT(RST_WAIT), .BLANK_CYC(BLANK_CYC)
    ) u_ch (
      .clock(clock),
      .rst(rst),
      .enable(enable[i]),
      .count(CNT_W'(slice_at(SLICE_VW'(count), i, CNT_W))),
      .fsync(fsync[i]),
      .tail_status(tail_status[i]),
      .tail_len(LSIZE'(slice_at(SLICE_VW'(tail_len), i, LSIZE))),
      .frame_tail_leave(frame_tail_leave[i]),
      .accept(accept[i]),
      .done_evt(done_evt[i]),
      .abort(abort[i]),
      .pend(pend[i]),
      .len(len_v[i]),
      .tail(tail_v[i]),
      .burst_done(burst_done[i]),
      .tail_done(tail_done[i])
    );
  end

  // a channel seeing fsync this cycle is about to leave PEND
  assign elig = pend & ~fsync;

  always_comb begin
    gnt_hit = 1'b0;
    gnt = '0;
    idx = 0;
    for (int k = 0; k < CH_NUM; k++) begin
      idx = (int'(rr) + k) % CH_NUM;
      if (!gnt_hit && elig[idx]) begin
        gnt_hit = 1'b1;
        gnt = CH_W'(idx);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      req_valid   <= 1'b0;
      req_ch      <= '0;
      req_len     <= LSIZE'(BURST_LEN);
      req_tail    <= 1'b0;
      outstanding <= 1'b0;
      rr          <= '0;
    end else begin
      if (req_valid) begin
        if (resp) begin
          req_valid   <= 1'b0;
          outstanding <= 1'b1;
          rr <= (req_ch == CH_W'(CH_NUM - 1)) ? '0 : req_ch + CH_W'(1);
        end else if (fsync[req_ch]) begin
          req_valid <= 1'b0;
        end
      end else if (!outstanding && gnt_hit) begin
        req_valid <= 1'b1;
        req_ch    <= gnt;
        req_len   <= len_v[gnt];
        req_tail  <= tail_v[gnt];
      end
      if (outstanding && (done || tmo)) outstanding <= 1'b0;
    end
  end

`ifdef FIFO_STATUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wd;

  assign tmo = outstanding && !done && (wd == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock) begin
    if (rst) begin
      wd  <= '0;
      err <= '0;
    end else begin
      wd  <= (outstanding && !tmo && !done) ? wd + TW'(1) : '0;
      err <= tmo ? sel : '0;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = '0;
`endif

endmodule

// File: tb/tb_fifo_status_ctrl_mc.sv
// Directed bench: READ/LINE two-channel instance and WRITE/ONCE one-channel
// instance, hand-computed latencies and pulses.
module tb_fifo_status_ctrl_mc;

  logic clock = 1'b0;
  logic rst = 1'b1;
  always #5 clock = ~clock;

  logic [1:0]  r_enable = '0, r_fsync = '0, r_tstat = '0, r_ftl = '0;
  logic [19:0] r_count = '0;
  logic [17:0] r_tlen = '0;
  logic        r_rv, r_ch, r_tail, r_resp = 1'b0, r_done = 1'b0;
  logic [8:0]  r_len;
  logic [1:0]  r_bd, r_td, r_err;

  logic        w_enable = 1'b0, w_fsync = 1'b0, w_tstat = 1'b0, w_ftl = 1'b0;
  logic [9:0]  w_count = '0;
  logic [8:0]  w_tlen = '0;
  logic        w_rv, w_ch, w_tail, w_resp = 1'b0, w_done = 1'b0;
  logic [8:0]  w_len;
  logic        w_bd, w_td, w_err;

  fifo_status_ctrl_mc #(
    .CH_NUM(2), .WR_RD("READ"), .MODE("LINE"), .TIMEOUT_CYC(16)
  ) u_rd (
    .clock(clock), .rst(rst), .enable(r_enable), .count(r_count),
    .fsync(r_fsync), .tail_status(r_tstat), .tail_len(r_tlen),
    .frame_tail_leave(r_ftl), .req_valid(r_rv), .req_ch(r_ch),
    .req_len(r_len), .req_tail(r_tail), .resp(r_resp), .done(r_done),
    .burst_done(r_bd), .tail_done(r_td), .err(r_err)
  );

  fifo_status_ctrl_mc #(
    .CH_NUM(1), .WR_RD("WRITE"), .MODE("ONCE"), .TIMEOUT_CYC(16)
  ) u_wr (
    .clock(clock), .rst(rst), .enable(w_enable), .count(w_count),
    .fsync(w_fsync), .tail_status(w_tstat), .tail_len(w_tlen),
    .frame_tail_leave(w_ftl), .req_valid(w_rv), .req_ch(w_ch),
    .req_len(w_len), .req_tail(w_tail), .resp(w_resp), .done(w_done),
    .burst_done(w_bd), .tail_done(w_td), .err(w_err)
  );

  int checks = 0;
  int failures = 0;
  int r_bd_cnt = 0, w_td_cnt = 0;

  always @(negedge clock) begin
    r_bd_cnt += $countones(r_bd);
    w_td_cnt += int'(w_td);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_rv(input bit sel, input int max, input string tag,
                         output int n);
    n = 0;
    while (!(sel ? w_rv : r_rv) && n < max) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, 32'(sel ? w_rv : r_rv), 1);
  endtask

  int n, c, b0, t0;

  initial begin
    r_enable = 2'b11;
    r_count = {10'd20, 10'd20};
    rst = 1'b1;
    tick();
    tick();
    chk("rst_rv", 32'(r_rv), 0);
    chk("rst_ch", 32'(r_ch), 0);
    chk("rst_len", 32'(r_len), 100);
    chk("rst_tail", 32'(r_tail), 0);
    chk("rst_pulses", {26'd0, r_bd, r_td, r_err}, 0);
    rst = 1'b0;

    wait_rv(0, 60, "boot", n);
    chk("boot_lat", n, 34);
    chk("boot_len", 32'(r_len), 100);

    for (int t = 0; t < 4; t++) begin
      wait_rv(0, 20, "rot", n);
      chk("rot_ch", 32'(r_ch), t % 2);
      chk("rot_len", 32'(r_len), 100);
      r_resp = 1'b1;
      tick();
      r_resp = 1'b0;
      chk("rot_drop", 32'(r_rv), 0);
      tick();
      tick();
      r_done = 1'b1;
      tick();
      r_done = 1'b0;
      chk("rot_bd", 32'(r_bd), (t % 2) ? 2 : 1);
    end

    r_enable = 2'b01;
    r_tstat = 2'b01;
    r_tlen = 18'd37;
    r_ftl = 2'b01;
    do_reset();
    wait_rv(0, 60, "tail", n);
    chk("tail_len", 32'(r_len), 37);
    chk("tail_flag", 32'(r_tail), 1);
    r_resp = 1'b1;
    tick();
    r_resp = 1'b0;
    tick();
    r_done = 1'b1;
    tick();
    r_done = 1'b0;
    chk("tail_td", 32'(r_td), 1);
    chk("tail_bd", 32'(r_bd), 0);
    c = 0;
    repeat (20) begin
      tick();
      c += int'(r_rv);
    end
    chk("hold_quiet", c, 0);
    r_fsync = 2'b01;
    tick();
    r_fsync = 2'b00;
    wait_rv(0, 40, "hold_rereq", n);
    chk("hold_rereq_lat", n, 7);
    r_ftl = 2'b00;
    r_resp = 1'b1;
    tick();
    r_resp = 1'b0;
    tick();
    r_done = 1'b1;
    tick();
    r_done = 1'b0;
    chk("line_td", 32'(r_td), 1);
    wait_rv(0, 20, "line_rereq", n);
    chk("line_rereq_lat", n, 3);

    r_enable = 2'b10;
    r_tstat = 2'b00;
    do_reset();
    wait_rv(0, 60, "cancel", n);
    chk("cancel_ch", 32'(r_ch), 1);
    b0 = r_bd_cnt;
    r_fsync = 2'b10;
    tick();
    r_fsync = 2'b00;
    chk("cancel_drop", 32'(r_rv), 0);
    r_done = 1'b1;
    tick();
    r_done = 1'b0;
    wait_rv(0, 60, "cancel_rereq", n);
    chk("cancel_rereq_lat", n + 1, 34);
    chk("cancel_no_bd", r_bd_cnt - b0, 0);

    b0 = r_bd_cnt;
    r_resp = 1'b1;
    r_fsync = 2'b10;
    tick();
    r_resp = 1'b0;
    r_fsync = 2'b00;
    chk("race_accept", 32'(r_rv), 0);
    tick();
    tick();
    r_done = 1'b1;
    tick();
    r_done = 1'b0;
    wait_rv(0, 60, "race_rereq", n);
    chk("race_rereq_lat", n, 34);
    chk("race_no_bd", r_bd_cnt - b0, 0);

    r_resp = 1'b1;
    tick();
    r_resp = 1'b0;
`ifdef FIFO_STATUS_TIMEOUT_EN
    c = 0;
    while (r_err == 2'b00 && c < 40) begin
      tick();
      c++;
    end
    chk("wd_cyc", c, 16);
    chk("wd_err", 32'(r_err), 2);
    b0 = r_bd_cnt;
    r_done = 1'b1;
    tick();
    r_done = 1'b0;
    chk("wd_err_pulse", 32'(r_err), 0);
    wait_rv(0, 60, "wd_rereq", n);
    chk("wd_rereq_lat", n + 1, 34);
    chk("wd_stale_done", r_bd_cnt - b0, 0);
`else
    c = 0;
    repeat (20) begin
      tick();
      c += $countones(r_err);
    end
    chk("no_wd_err", c, 0);
    r_done = 1'b1;
    tick();
    r_done = 1'b0;
    chk("no_wd_bd", 32'(r_bd), 2);
`endif

    r_enable = 2'b00;
    w_enable = 1'b1;
    w_count = 10'd200;
    do_reset();
    c = 0;
    repeat (60) begin
      tick();
      c += int'(w_rv);
    end
    chk("wr_200_quiet", c, 0);
    w_count = 10'd201;
    wait_rv(1, 10, "wr_201", n);
    chk("wr_201_lat", n, 3);
    chk("wr_ch", 32'(w_ch), 0);
    chk("wr_len", 32'(w_len), 100);
    chk("wr_tail", 32'(w_tail), 0);
    w_resp = 1'b1;
    tick();
    w_resp = 1'b0;
    w_count = 10'd200;
    repeat (3) tick();
    w_done = 1'b1;
    tick();
    w_done = 1'b0;
    chk("wr_bd", 32'(w_bd), 1);
    repeat (4) tick();
    w_tstat = 1'b1;
    w_tlen = 9'd0;
    t0 = w_td_cnt;
    w_count = 10'd201;
    tick();
    tick();
    chk("wr_tail0_td", 32'(w_td), 1);
    c = 0;
    repeat (20) begin
      tick();
      c += int'(w_rv);
    end
    chk("wr_tail0_no_req", c, 0);
    chk("wr_tail0_once", w_td_cnt - t0, 1);
    chk("wr_err", 32'(w_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_status_ctrl_mc.md
Name: fifo_status_ctrl_mc

Overview:
Multi-channel successor of the single-channel VDMA FIFO status controller. Watches the fill counts of CH_NUM line FIFOs in one mode: READ (refill when nearly empty) or WRITE (drain when above threshold). Issues burst or tail requests to one shared DMA engine through a round-robin arbiter, with at most one transaction outstanding. Sits between the per-channel stream FIFOs and the AXI burst engine.

Parameters:
CH_NUM, 2, number of FIFO channels (1..8)
CNT_W, 10, width of each FIFO count
LSIZE, 9, request length width
FULL_LEN, 256, FIFO depth in words
THRESHOLD, 200, READ: trigger when count < FULL_LEN-THRESHOLD; WRITE: trigger when count > THRESHOLD
BURST_LEN, 100, normal burst length
MODE, "ONCE", "ONCE" or "LINE" tail handling
WR_RD, "READ", "READ" or "WRITE"
RST_WAIT, 31, fsync-free cycles required after reset/fsync before requests are allowed
BLANK_CYC, 4, trigger blanking after each fsync
TIMEOUT_CYC, 4096, done watchdog limit (optional feature only)

Ports:
clock  in  1  single clock
rst  in  1  synchronous active-high reset
enable  in  CH_NUM  per-channel enable
count  in  CH_NUM*CNT_W  packed FIFO counts, channel i at [i*CNT_W +: CNT_W]
fsync  in  CH_NUM  per-channel frame sync / FIFO reset
tail_status  in  CH_NUM  next request of channel is a line/frame tail
tail_len  in  CH_NUM*LSIZE  packed tail lengths
frame_tail_leave  in  CH_NUM  last tail of frame (LINE mode)
req_valid  out  1  request to DMA engine
req_ch  out  $clog2(CH_NUM) (min 1)  requesting channel
req_len  out  LSIZE  request length
req_tail  out  1  request is a tail
resp  in  1  engine accepts request (valid only with req_valid)
done  in  1  engine finished outstanding request
burst_done  out  CH_NUM  1-cycle pulse per channel
tail_done  out  CH_NUM  1-cycle pulse per channel
err  out  CH_NUM  1-cycle timeout pulse (0 without feature)

Behaviour:
- Reset: all channels in WAIT_RST; req_valid=0, req_ch=0, req_len=BURST_LEN, req_tail=0, burst_done/tail_done/err=0, rr pointer=0, no outstanding transaction.
- Trigger per channel, registered: enable & threshold compare & !fsync & blank counter==0. The blank counter loads BLANK_CYC on fsync and decrements to 0.
- Channel FSM: WAIT_RST, IDLE, PEND, ACTIVE, FSH, HOLD.
- WAIT_RST: a counter increments while !fsync and clears on fsync; go to IDLE when counter==RST_WAIT.
- IDLE: trigger -> PEND. Length captured at entry: tail_status ? tail_len : BURST_LEN; the tail flag is latched. A tail with tail_len==0 skips PEND, goes to FSH, and pulses tail_done.
- PEND: waits for grant. fsync -> WAIT_RST, request dropped.
- ACTIVE: granted and accepted; done -> FSH. An fsync seen here is remembered, and the FSM goes to WAIT_RST after done instead of FSH, with no done pulse.
- FSH (1 cycle): pulses burst_done or tail_done. Non-tail -> IDLE. Tail, ONCE mode -> HOLD. Tail, LINE mode -> HOLD if frame_tail_leave, else IDLE.
- HOLD: fsync -> IDLE (bypasses WAIT_RST).
- Arbiter: when nothing is outstanding and any channel is in PEND, register the grant to the first PEND channel at or after the rr pointer. req_valid/req_ch/req_len/req_tail are registered and held stable until resp.
- resp with req_valid: clears req_valid, marks the transaction outstanding, moves the granted channel to ACTIVE, and sets rr pointer = granted+1 (mod CH_NUM).
- done with nothing outstanding: ignored.
- If the granted channel receives fsync while req_valid is high and before resp: drop req_valid the next cycle, no acceptance.
- Latency: count condition at cycle N -> trigger N+1 -> PEND N+2 -> req_valid N+3. done at M -> done pulse at M+1.
- Simultaneous resp and fsync on the granted channel: resp wins; the fsync is treated as fsync during ACTIVE.

Optional Feature:
FIFO_STATUS_TIMEOUT_EN
- Defined: a watchdog counts cycles with a transaction outstanding. When it reaches TIMEOUT_CYC, pulse err[ch] for 1 cycle, clear outstanding, send the channel to WAIT_RST, and ignore a later stale done.
- Undefined: no watchdog; err tied to 0.

Decomposition:
- Package fifo_status_pkg: channel state enum, the WR_RD/MODE string constants, and the packed-slice helper function.
- One sub-module fifo_status_ch, instantiated CH_NUM times: per-channel trigger, blanking, WAIT_RST counter and FSM.
- Arbiter and request registers stay in the top.

Test Plan:
- Reset, CH_NUM=2, READ, both counts=20, no fsync: no req_valid for the first RST_WAIT+2 cycles. Then req_valid with req_ch=0, req_len=100.
- Both channels pending: resp, done on ch0, then ch1 is granted next with req_ch=1, and grants alternate 0,1,0,1 over 4 transactions.
- tail_status=1, tail_len=37, LINE mode, frame_tail_leave=1: req_len=37, req_tail=1. done -> tail_done pulse, channel stays silent until fsync.
- fsync on ch1 while it is in PEND and holds the grant: req_valid drops the cycle after, no burst_done. ch1 re-requests only after RST_WAIT fsync-free cycles.
- WRITE mode, count=201 vs 200: 201 triggers, 200 does not. tail_len=0 -> tail_done pulse with no req_valid.
- With FIFO_STATUS_TIMEOUT_EN defined and TIMEOUT_CYC=16: resp with no done -> err pulse at the 16th cycle. A later done is ignored, and the channel returns to WAIT_RST.
